// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 flash reader issuing 0x03 + 24-bit address, then streaming len_m1+1 bytes.
// Ports: clk/reset (sync, active-high); start/addr/len_m1 request a read when idle; stop aborts;
// busy/done/data/data_valid report progress; spi_cs_n/spi_sclk/spi_mosi/spi_miso are the flash pins.
module spi_flash_reader #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len_m1,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [7:0]       data,
  output logic             data_valid,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMD  = 3'd1;
  localparam logic [2:0] ADDR = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  logic [2:0]       state_q, state_d;
  logic             phase_q, phase_d;
  logic [4:0]       bit_q, bit_d;
  logic [LEN_W-1:0] byte_q, byte_d, len_q, len_d;
  logic [31:0]      sr_q, sr_d;
  logic [6:0]       rx_q, rx_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d;
  logic             cs_n_q, cs_n_d;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    len_d   = len_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CMD;
        phase_d = 1'b0;
        bit_d   = '0;
        byte_d  = '0;
        len_d   = len_m1;
        sr_d    = {8'h03, addr};
      end
      CMD, ADDR, DATA: begin
        phase_d = ~phase_q;
        // A bit completes at the edge ending its high phase: shift out next, sample miso.
        if (phase_q) begin
          sr_d  = {sr_q[30:0], 1'b0};
          bit_d = bit_q + 5'd1;
          if (state_q == CMD && bit_q == 5'd7) begin
            state_d = ADDR;
            bit_d   = '0;
          end
          if (state_q == ADDR && bit_q == 5'd23) begin
            state_d = DATA;
            bit_d   = '0;
          end
          if (state_q == DATA) begin
            rx_d = {rx_q[5:0], spi_miso};
            if (bit_q == 5'd7) begin
              dv_d    = 1'b1;
              data_d  = {rx_q, spi_miso};
              bit_d   = '0;
              byte_d  = byte_q + 1'b1;
              state_d = (byte_q == len_q) ? DONE : DATA;
            end
          end
        end
        if (stop) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Entering DONE parks the bus: sclk low, mosi low.
    if (state_d == DONE) begin
      phase_d = 1'b0;
      sr_d    = '0;
    end
    cs_n_d = !(state_d == CMD || state_d == ADDR || state_d == DATA);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      bit_q   <= '0;
      byte_q  <= '0;
      len_q   <= '0;
      sr_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      cs_n_q  <= cs_n_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_sclk   = phase_q;
  assign spi_mosi   = sr_q[31];
endmodule
